// File: rtl/power_pkg.sv
// Shared types and helpers for the power-mode controller.
// The POWER_LOCK_EN macro (see power_mode_ctrl) does not affect this package.
package power_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam int unsigned MODE_TRAINING = 0;
    localparam int unsigned MODE_DUELING  = 1;
    localparam int unsigned MODE_BULKHEAD = 2;

    // Widest mode vector the helper accepts; callers zero-extend into it.
    localparam int unsigned MAX_MODES = 32;

    function automatic logic is_onehot(input logic [MAX_MODES-1:0] v);
        return (v != '0) && ((v & (v - MAX_MODES'(1))) == '0);
    endfunction

endpackage

// File: rtl/power_mode_ctrl_ramp_timer.sv
// Break-before-make ramp counter: loaded with RAMP_CYCLES, counts down,
// flags the final ramp cycle. Unaffected by POWER_LOCK_EN.
module ramp_timer #(
    parameter int unsigned RAMP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int unsigned CW = $clog2(RAMP_CYCLES + 1);

    logic [CW-1:0] count;

    // Saturates at zero so it can never wrap, even if dec is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(RAMP_CYCLES);
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/power_mode_ctrl.sv
// One-hot power mode register with valid/ready change requests and a timed
// all-rails-off ramp. Optional lock feature enabled by defining POWER_LOCK_EN.
module power_mode_ctrl
    import power_pkg::*;
#(
    parameter int unsigned N_MODES      = 3,
    parameter int unsigned RAMP_CYCLES  = 4,
    parameter int unsigned DEFAULT_MODE = MODE_TRAINING
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [N_MODES-1:0] req_mode,
    output logic               req_ready,
    output logic [N_MODES-1:0] mode_out,
    output logic               busy,
    output logic               mode_changed,
    output logic               err_illegal
`ifdef POWER_LOCK_EN
    ,
    input  logic               lock,
    output logic               err_locked
`endif
);

    localparam logic [N_MODES-1:0] RESET_MODE = N_MODES'(1) << DEFAULT_MODE;

    state_t             state_q, state_d;
    logic [N_MODES-1:0] mode_q, mode_d;
    logic [N_MODES-1:0] pending_q, pending_d;
    logic               busy_q, busy_d;
    logic               changed_q, changed_d;
    logic               illegal_q, illegal_d;
    logic               locked_d;
    logic               lock_hit;
    logic               req_legal;
    logic               timer_load, timer_dec, timer_last;

`ifdef POWER_LOCK_EN
    logic locked_q;
    assign lock_hit = lock;
`else
    assign lock_hit = 1'b0;
`endif

    assign req_legal = is_onehot(MAX_MODES'(req_mode));

    ramp_timer #(
        .RAMP_CYCLES(RAMP_CYCLES)
    ) u_ramp_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .last (timer_last)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pending_d  = pending_q;
        changed_d  = 1'b0;
        illegal_d  = 1'b0;
        locked_d   = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!req_legal) begin
                        illegal_d = 1'b1;
                    end else if (req_mode != mode_q) begin
                        if (lock_hit) begin
                            locked_d = 1'b1;
                        end else begin
                            pending_d  = req_mode;
                            mode_d     = '0;
                            timer_load = 1'b1;
                            state_d    = RAMP;
                        end
                    end
                end
            end
            RAMP: begin
                timer_dec = 1'b1;
                if (timer_last) begin
                    mode_d    = pending_q;
                    changed_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mode_q    <= RESET_MODE;
            pending_q <= '0;
            busy_q    <= 1'b0;
            changed_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            changed_q <= changed_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef POWER_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end
    assign err_locked = locked_q;
`endif

    assign req_ready    = (state_q == IDLE);
    assign mode_out     = mode_q;
    assign busy         = busy_q;
    assign mode_changed = changed_q;
    assign err_illegal  = illegal_q;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Self-checking bench for power_mode_ctrl: directed scenarios plus randomized
// traffic against a behavioural model. Lock scenario built when POWER_LOCK_EN is defined.
module tb_power_mode_ctrl;

    localparam int unsigned N = 3;
    localparam int unsigned R = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [N-1:0] req_mode;
    logic         req_ready;
    logic [N-1:0] mode_out;
    logic         busy;
    logic         mode_changed;
    logic         err_illegal;
    logic         lock_v;
`ifdef POWER_LOCK_EN
    logic         err_locked;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: current mode, target, ramp cycles still to run, pulses.
    logic [N-1:0] m_mode;
    logic [N-1:0] m_target;
    int           m_ramp;
    logic         m_changed, m_illegal, m_locked;

    power_mode_ctrl #(
        .N_MODES      (N),
        .RAMP_CYCLES  (R),
        .DEFAULT_MODE (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .mode_out     (mode_out),
        .busy         (busy),
        .mode_changed (mode_changed),
        .err_illegal  (err_illegal)
`ifdef POWER_LOCK_EN
        ,
        .lock         (lock_v),
        .err_locked   (err_locked)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode    = 3'b001;
        m_target  = '0;
        m_ramp    = 0;
        m_changed = 1'b0;
        m_illegal = 1'b0;
        m_locked  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [N-1:0] m, input logic lk);
        m_changed = 1'b0;
        m_illegal = 1'b0;
        m_locked  = 1'b0;
        if (m_ramp > 0) begin
            m_ramp = m_ramp - 1;
            if (m_ramp == 0) begin
                m_mode    = m_target;
                m_changed = 1'b1;
            end
        end else if (v) begin
            if ($countones(m) != 1) begin
                m_illegal = 1'b1;
            end else if (m != m_mode) begin
                if (lk) begin
                    m_locked = 1'b1;
                end else begin
                    m_target = m;
                    m_mode   = '0;
                    m_ramp   = R;
                end
            end
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        model_step(req_valid, req_mode, lock_v);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_mode = '0; lock_v = 1'b0;
        model_reset();
        #23;
        n_cmp++; if (mode_out !== 3'b001) begin n_err++; $display("FAIL reset_mode: got %b want 001", mode_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({mode_changed, err_illegal} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {mode_changed, err_illegal}); end
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (mode_out !== 3'b001) begin n_err++; $display("FAIL post_reset_mode: got %b want 001", mode_out); end
    endtask

    task automatic test_legal_change();
        req_valid = 1'b1; req_mode = 3'b100;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= int'(R); i++) begin
            n_cmp++; if ({mode_out, busy, req_ready} !== 5'b000_1_0) begin
                n_err++; $display("FAIL ramp_cycle%0d: got mode=%b busy=%b ready=%b want 000/1/0", i, mode_out, busy, req_ready);
            end
            if (i < int'(R)) tick();
        end
        tick();
        n_cmp++; if ({mode_out, busy, mode_changed} !== 5'b100_0_1) begin
            n_err++; $display("FAIL ramp_done: got mode=%b busy=%b chg=%b want 100/0/1", mode_out, busy, mode_changed);
        end
        tick();
        n_cmp++; if (mode_changed !== 1'b0) begin n_err++; $display("FAIL changed_pulse_len: got %b want 0", mode_changed); end
    endtask

    task automatic test_illegal();
        logic [N-1:0] bad [2];
        bad[0] = 3'b011;
        bad[1] = 3'b000;
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1; req_mode = bad[k];
            tick();
            req_valid = 1'b0;
            n_cmp++; if ({err_illegal, mode_out, busy} !== 5'b1_100_0) begin
                n_err++; $display("FAIL illegal_%b: got err=%b mode=%b busy=%b want 1/100/0", bad[k], err_illegal, mode_out, busy);
            end
            tick();
            n_cmp++; if (err_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_pulse_len_%b: got %b want 0", bad[k], err_illegal); end
        end
        req_valid = 1'b1; req_mode = 3'b100;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({mode_out, busy, mode_changed, err_illegal, req_ready} !== 7'b100_0_0_0_1) begin
            n_err++; $display("FAIL same_mode_noop: got mode=%b busy=%b chg=%b ill=%b rdy=%b want 100/0/0/0/1",
                              mode_out, busy, mode_changed, err_illegal, req_ready);
        end
    endtask

    task automatic test_busy_ignore();
        req_valid = 1'b1; req_mode = 3'b001;
        tick();
        req_mode = 3'b010;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready_%0d: got %b want 0", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        tick();
        n_cmp++; if ({mode_out, mode_changed} !== 4'b001_1) begin
            n_err++; $display("FAIL busy_final: got mode=%b chg=%b want 001/1", mode_out, mode_changed);
        end
        tick();
        n_cmp++; if ({mode_out, busy} !== 4'b001_0) begin
            n_err++; $display("FAIL busy_no_second: got mode=%b busy=%b want 001/0", mode_out, busy);
        end
    endtask

    task automatic test_reset_mid_ramp();
        req_valid = 1'b1; req_mode = 3'b010;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({mode_out, busy} !== 4'b001_0) begin
            n_err++; $display("FAIL async_reset: got mode=%b busy=%b want 001/0", mode_out, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ramp_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_mode = 3'b100;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < int'(R); i++) tick();
        n_cmp++; if ({mode_out, mode_changed, busy} !== 5'b100_1_0) begin
            n_err++; $display("FAIL after_reset_change: got mode=%b chg=%b busy=%b want 100/1/0", mode_out, mode_changed, busy);
        end
        tick();
    endtask

`ifdef POWER_LOCK_EN
    task automatic test_lock();
        lock_v = 1'b1; req_valid = 1'b1; req_mode = 3'b010;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({err_locked, mode_out, busy} !== 5'b1_100_0) begin
            n_err++; $display("FAIL lock_refuse: got el=%b mode=%b busy=%b want 1/100/0", err_locked, mode_out, busy);
        end
        tick();
        n_cmp++; if (err_locked !== 1'b0) begin n_err++; $display("FAIL lock_pulse_len: got %b want 0", err_locked); end
        lock_v = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({mode_out, busy} !== 4'b000_1) begin
            n_err++; $display("FAIL unlock_ramp: got mode=%b busy=%b want 000/1", mode_out, busy);
        end
        for (int i = 0; i < int'(R); i++) tick();
        n_cmp++; if (mode_out !== 3'b010) begin n_err++; $display("FAIL unlock_final: got %b want 010", mode_out); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) req_mode = N'($urandom_range(0, 7));
            else req_mode = N'(1) << $urandom_range(0, N - 1);
`ifdef POWER_LOCK_EN
            lock_v = ($urandom_range(0, 4) == 0);
`endif
            tick();
            n_cmp++;
            if ({mode_out, busy, req_ready, mode_changed, err_illegal} !==
                {m_mode, (m_ramp > 0), (m_ramp == 0), m_changed, m_illegal}) begin
                n_err++;
                $display("FAIL random_%0d: got mode=%b busy=%b rdy=%b chg=%b ill=%b want %b/%b/%b/%b/%b",
                         i, mode_out, busy, req_ready, mode_changed, err_illegal,
                         m_mode, (m_ramp > 0), (m_ramp == 0), m_changed, m_illegal);
            end
`ifdef POWER_LOCK_EN
            n_cmp++; if (err_locked !== m_locked) begin n_err++; $display("FAIL random_lock_%0d: got %b want %b", i, err_locked, m_locked); end
`endif
            n_cmp++; if ($countones(mode_out) > 1) begin n_err++; $display("FAIL random_onehot_%0d: got %b want one-hot or zero", i, mode_out); end
        end
        req_valid = 1'b0;
        lock_v = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_change();
        test_illegal();
        test_busy_ignore();
        test_reset_mid_ramp();
`ifdef POWER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
